// File: rtl/input_conditioner_pkg.sv
// rtl/input_conditioner_pkg.sv - shared constants for the input conditioner front end
package input_conditioner_pkg;

   localparam int DEBOUNCE_DEFAULT = 1000000;
   localparam int DEBOUNCE_SIM     = 4;
   localparam int SYNC_STAGES      = 2;

endpackage

// File: rtl/input_conditioner_debounce.sv
// rtl/input_conditioner_debounce.sv - one synchronised, debounced input with rising-edge pulse
module debounce_channel
   import input_conditioner_pkg::*;
#(
   parameter  int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic rise,
   output logic pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CNT_W-1:0]       cnt;
   logic                   s;
   logic                   flip;

   assign s    = sync[SYNC_STAGES-1];
   assign flip = (s != level) && (cnt == CNT_LAST);
   // rise is the combinational "pulse on this edge" term, used to qualify captures alongside pulse
   assign rise = flip && s;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync  <= '0;
         cnt   <= '0;
         level <= 1'b0;
         pulse <= 1'b0;
      end else begin
         sync  <= {sync[SYNC_STAGES-2:0], raw};
         pulse <= rise;
         if (s == level) begin
            cnt <= '0;
         end else if (flip) begin
            level <= s;
            cnt   <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/input_conditioner.sv
// rtl/input_conditioner.sv - debounces four buttons and captures time switches on reprogram
module input_conditioner
   import input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       Reset_Raw,
   input  logic       Sensor_Raw,
   input  logic       Walk_Raw,
   input  logic       Reprog_Raw,
   input  logic [1:0] Selector_Raw,
   input  logic [3:0] Value_Raw,
   output logic       Reset_Clean,
   output logic       Sensor_Clean,
   output logic       Walk_Pulse,
   output logic       Reprog_Pulse,
   output logic [1:0] Selector_Out,
   output logic [3:0] Value_Out
);

   logic reset_rise, reset_pulse;
   logic sensor_rise, sensor_pulse;
   logic walk_level, walk_rise;
   logic reprog_level, reprog_rise;
   logic unused_chan;

   assign unused_chan = ^{reset_rise, reset_pulse, sensor_rise, sensor_pulse,
                          walk_level, walk_rise, reprog_level};

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset (
      .clk(clk), .rst(rst), .raw(Reset_Raw),
      .level(Reset_Clean), .rise(reset_rise), .pulse(reset_pulse)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sensor (
      .clk(clk), .rst(rst), .raw(Sensor_Raw),
      .level(Sensor_Clean), .rise(sensor_rise), .pulse(sensor_pulse)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_walk (
      .clk(clk), .rst(rst), .raw(Walk_Raw),
      .level(walk_level), .rise(walk_rise), .pulse(Walk_Pulse)
   );

   debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reprog (
      .clk(clk), .rst(rst), .raw(Reprog_Raw),
      .level(reprog_level), .rise(reprog_rise), .pulse(Reprog_Pulse)
   );

   // Switches are only synchronised; the debounced reprogram edge is what makes them consistent
   logic [SYNC_STAGES-1:0][5:0] sw_sync;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sw_sync      <= '0;
         Selector_Out <= '0;
         Value_Out    <= '0;
      end else begin
         sw_sync <= {sw_sync[SYNC_STAGES-2:0], {Selector_Raw, Value_Raw}};
         if (reprog_rise) begin
            Selector_Out <= sw_sync[SYNC_STAGES-1][5:4];
            Value_Out    <= sw_sync[SYNC_STAGES-1][3:0];
         end
      end
   end

endmodule

// File: tb/tb_input_conditioner.sv
// tb/tb_input_conditioner.sv - directed and random checks of input_conditioner against a run-length model
module tb_input_conditioner;
   import input_conditioner_pkg::*;

   localparam int D = DEBOUNCE_SIM;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       Reset_Raw = 1'b0, Sensor_Raw = 1'b0, Walk_Raw = 1'b0, Reprog_Raw = 1'b0;
   logic [1:0] Selector_Raw = '0;
   logic [3:0] Value_Raw = '0;
   logic       Reset_Clean, Sensor_Clean, Walk_Pulse, Reprog_Pulse;
   logic [1:0] Selector_Out;
   logic [3:0] Value_Out;

   int errors = 0;
   int checks = 0;

   // Model: per channel, recent raw samples and the run of synchronised values since the last flip
   int         raw_hist [4][$];
   int         s_run    [4][$];
   logic [3:0] mq;
   logic [3:0] mpulse;
   int         sw_hist [$];
   logic [5:0] msw;

   int wcnt, rcnt, wedge, redge, scnt;
   logic [1:0] cap_sel;
   logic [3:0] cap_val;

   input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
      .clk(clk), .rst(rst),
      .Reset_Raw(Reset_Raw), .Sensor_Raw(Sensor_Raw), .Walk_Raw(Walk_Raw), .Reprog_Raw(Reprog_Raw),
      .Selector_Raw(Selector_Raw), .Value_Raw(Value_Raw),
      .Reset_Clean(Reset_Clean), .Sensor_Clean(Sensor_Clean),
      .Walk_Pulse(Walk_Pulse), .Reprog_Pulse(Reprog_Pulse),
      .Selector_Out(Selector_Out), .Value_Out(Value_Out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int ch = 0; ch < 4; ch++) begin
         raw_hist[ch].delete();
         s_run[ch].delete();
      end
      mq = '0;
      mpulse = '0;
      sw_hist.delete();
      msw = '0;
   endtask

   task automatic model_edge();
      logic [3:0] r;
      int         s, sz, swv;
      bit         all_diff;
      r = {Reprog_Raw, Walk_Raw, Sensor_Raw, Reset_Raw};
      for (int ch = 0; ch < 4; ch++) begin
         // value seen by the debouncer now is the raw sample from two edges ago
         s = (raw_hist[ch].size() >= 2) ? raw_hist[ch][raw_hist[ch].size()-2] : 0;
         raw_hist[ch].push_back(int'(r[ch]));
         if (raw_hist[ch].size() > 2) void'(raw_hist[ch].pop_front());
         s_run[ch].push_back(s);
         if (s_run[ch].size() > D) void'(s_run[ch].pop_front());
         mpulse[ch] = 1'b0;
         sz = s_run[ch].size();
         if (sz == D) begin
            all_diff = 1;
            for (int k = 0; k < D; k++)
               if (s_run[ch][k] == int'(mq[ch])) all_diff = 0;
            if (all_diff) begin
               mq[ch]     = s[0];
               mpulse[ch] = s[0];
               s_run[ch].delete();
            end
         end
      end
      swv = (sw_hist.size() >= 2) ? sw_hist[sw_hist.size()-2] : 0;
      sw_hist.push_back(int'({Selector_Raw, Value_Raw}));
      if (sw_hist.size() > 2) void'(sw_hist.pop_front());
      if (mpulse[3]) msw = swv[5:0];
   endtask

   task automatic compare_all();
      check("reset_clean",  8'(Reset_Clean),  8'(mq[0]));
      check("sensor_clean", 8'(Sensor_Clean), 8'(mq[1]));
      check("walk_pulse",   8'(Walk_Pulse),   8'(mpulse[2]));
      check("reprog_pulse", 8'(Reprog_Pulse), 8'(mpulse[3]));
      check("selector_out", 8'(Selector_Out), 8'(msw[5:4]));
      check("value_out",    8'(Value_Out),    8'(msw[3:0]));
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic apply_reset();
      rst = 1'b0;
      #1;
      model_clear();
      check("rst_outputs_zero",
            8'({Reset_Clean, Sensor_Clean, Walk_Pulse, Reprog_Pulse, Selector_Out, Value_Out}), 8'h00);
      #1;
      rst = 1'b1;
   endtask

   initial begin
      model_clear();

      // T1: all raw high through reset; levels rise and pulses fire after edge 6
      Reset_Raw = 1; Sensor_Raw = 1; Walk_Raw = 1; Reprog_Raw = 1;
      apply_reset();
      ticks(5);
      check("t1_reset_clean_e5", 8'(Reset_Clean), 8'd0);
      check("t1_walk_e5", 8'(Walk_Pulse), 8'd0);
      tick();
      check("t1_reset_clean_e6", 8'(Reset_Clean), 8'd1);
      check("t1_sensor_clean_e6", 8'(Sensor_Clean), 8'd1);
      check("t1_walk_e6", 8'(Walk_Pulse), 8'd1);
      check("t1_reprog_e6", 8'(Reprog_Pulse), 8'd1);
      tick();
      check("t1_walk_e7", 8'(Walk_Pulse), 8'd0);
      check("t1_reprog_e7", 8'(Reprog_Pulse), 8'd0);
      Reset_Raw = 0; Sensor_Raw = 0; Walk_Raw = 0; Reprog_Raw = 0;
      ticks(10);

      // T2: 3-cycle press rejected, 4-cycle press accepted at edge 6
      wcnt = 0;
      Walk_Raw = 1;
      for (int i = 1; i <= 3; i++) begin tick(); if (Walk_Pulse) wcnt++; end
      Walk_Raw = 0;
      for (int i = 1; i <= 10; i++) begin tick(); if (Walk_Pulse) wcnt++; end
      check("t2_short_press_pulses", 8'(wcnt), 8'd0);
      wcnt = 0; wedge = 0;
      Walk_Raw = 1;
      for (int i = 1; i <= 4; i++) begin tick(); if (Walk_Pulse) begin wcnt++; wedge = i; end end
      Walk_Raw = 0;
      for (int i = 5; i <= 14; i++) begin tick(); if (Walk_Pulse) begin wcnt++; wedge = i; end end
      check("t2_held_press_pulses", 8'(wcnt), 8'd1);
      check("t2_held_press_edge", 8'(wedge), 8'd6);

      // T3: bounce then hold; level rises 6 edges after final rise
      Sensor_Raw = 1; tick();
      Sensor_Raw = 0; tick();
      Sensor_Raw = 1; tick();
      Sensor_Raw = 0; tick();
      Sensor_Raw = 1;
      scnt = 0;
      for (int i = 1; i <= 10; i++) begin tick(); if (Sensor_Clean && scnt == 0) scnt = i; end
      check("t3_bounce_latency", 8'(scnt), 8'd6);
      Sensor_Raw = 0;
      ticks(8);

      // T4: switch capture on reprogram, then held when switches change
      Selector_Raw = 2'b10; Value_Raw = 4'd9; Reprog_Raw = 1;
      rcnt = 0; redge = 0; cap_sel = '0; cap_val = '0;
      for (int i = 1; i <= 8; i++) begin
         tick();
         if (Reprog_Pulse) begin rcnt++; redge = i; cap_sel = Selector_Out; cap_val = Value_Out; end
      end
      check("t4_pulse_count", 8'(rcnt), 8'd1);
      check("t4_pulse_edge", 8'(redge), 8'd6);
      check("t4_selector_at_pulse", 8'(cap_sel), 8'd2);
      check("t4_value_at_pulse", 8'(cap_val), 8'd9);
      Selector_Raw = 2'b01; Value_Raw = 4'd3;
      ticks(10);
      check("t4_selector_held", 8'(Selector_Out), 8'd2);
      check("t4_value_held", 8'(Value_Out), 8'd9);
      Reprog_Raw = 0;
      ticks(8);

      // T5: simultaneous presses held 100 cycles
      Walk_Raw = 1; Reprog_Raw = 1;
      wcnt = 0; rcnt = 0; wedge = 0; redge = 0;
      for (int i = 1; i <= 106; i++) begin
         tick();
         if (Walk_Pulse) begin wcnt++; wedge = i; end
         if (Reprog_Pulse) begin rcnt++; redge = i; end
      end
      check("t5_walk_count", 8'(wcnt), 8'd1);
      check("t5_reprog_count", 8'(rcnt), 8'd1);
      check("t5_walk_edge", 8'(wedge), 8'd6);
      check("t5_reprog_edge", 8'(redge), 8'd6);
      Walk_Raw = 0; Reprog_Raw = 0;
      ticks(8);

      // T6: reset mid-count with walk held restarts full latency
      Walk_Raw = 1;
      ticks(4);
      apply_reset();
      wcnt = 0; wedge = 0;
      for (int i = 1; i <= 12; i++) begin tick(); if (Walk_Pulse) begin wcnt++; wedge = i; end end
      check("t6_pulse_count", 8'(wcnt), 8'd1);
      check("t6_pulse_edge", 8'(wedge), 8'd6);
      Walk_Raw = 0;
      ticks(8);

      // Random phase: sparse toggles so both glitches and held presses occur
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 5) == 0) Reset_Raw  = ~Reset_Raw;
         if ($urandom_range(0, 5) == 0) Sensor_Raw = ~Sensor_Raw;
         if ($urandom_range(0, 5) == 0) Walk_Raw   = ~Walk_Raw;
         if ($urandom_range(0, 5) == 0) Reprog_Raw = ~Reprog_Raw;
         if ($urandom_range(0, 3) == 0) begin
            Selector_Raw = 2'($urandom_range(0, 3));
            Value_Raw    = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 249) == 0) apply_reset();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
Front-end stage that sits directly upstream of the traffic controller top level and drives its raw inputs.
- Synchronises and debounces the four pushbutton/switch inputs.
- Converts Walk_Request and Reprogram into single-cycle pulses.
- Captures the time-programming switches on the debounced Reprogram edge, so the controller sees glitch-free, mutually consistent values.

Parameters:
DEBOUNCE_CYCLES, 1000000, consecutive clk cycles a synchronised input must differ from its stable value before the stable value flips (legal range >= 2).
CNT_W, $clog2(DEBOUNCE_CYCLES), width of each debounce counter; derived, never overridden.

Ports:
clk  input  1  system clock, single domain
rst  input  1  asynchronous, active-low reset
Reset_Raw  input  1  raw reset pushbutton
Sensor_Raw  input  1  raw side-street sensor
Walk_Raw  input  1  raw walk pushbutton
Reprog_Raw  input  1  raw reprogram pushbutton
Selector_Raw  input  2  raw time-parameter selector switches
Value_Raw  input  4  raw time-value switches
Reset_Clean  output  1  debounced level of Reset_Raw
Sensor_Clean  output  1  debounced level of Sensor_Raw
Walk_Pulse  output  1  one-cycle pulse on debounced rising edge of Walk_Raw
Reprog_Pulse  output  1  one-cycle pulse on debounced rising edge of Reprog_Raw
Selector_Out  output  2  selector captured on Reprog_Pulse
Value_Out  output  4  time value captured on Reprog_Pulse

Behaviour:
- rst low (asynchronous): every output is 0, every synchroniser flop is 0, every stable flag is 0 and every counter is 0. Outputs are held at 0 until the first qualifying edge after rst returns high.
- Per 1-bit channel:
  - 2-flop synchroniser produces s.
  - Stable flag q and counter c (CNT_W bits).
  - Each edge: if s == q, c <= 0. Else if c == DEBOUNCE_CYCLES-1, q <= s and c <= 0. Else c <= c+1.
- Latency: a raw change that precedes edge 0 and is held appears on q (and on any pulse) after edge 2+DEBOUNCE_CYCLES. Latency is exact, not a bound.
- Glitch rejection:
  - A raw excursion whose synchronised version lasts < DEBOUNCE_CYCLES cycles never changes q.
  - Any return of s to q clears c, so bounces restart the count.
- Pulse channels (Walk, Reprog):
  - Pulse register is set on the same edge where q goes 0->1, and is 0 on every other edge.
  - Exactly one cycle wide per press.
  - Holding a button produces no further pulses.
  - Falling edges produce nothing.
- Level channels (Reset, Sensor): Reset_Clean and Sensor_Clean equal q.
- Switch capture:
  - Selector_Raw and Value_Raw pass through 2-flop synchronisers only; they are not debounced.
  - On the edge that sets Reprog_Pulse, Selector_Out and Value_Out load the synchronised switch values. Pulse and data are therefore valid together in the same cycle.
  - Selector_Out and Value_Out hold between captures.
- Simultaneous events: channels are fully independent. Walk and Reprog pulses in the same cycle are both issued.
- Reset mid-count: counters are cleared and q goes to 0. If a raw input is still high after release, the full 2+DEBOUNCE_CYCLES latency applies again, and a pulse channel fires once (q rises from 0).
- Counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1, so no wrap is possible.

Decomposition:
- Shared package holds:
  - default DEBOUNCE_CYCLES constant (1000000);
  - simulation override value (4);
  - synchroniser depth constant (2).
- One sub-module, debounce_channel (synchroniser, counter, stable flag, rising-edge pulse), instantiated four times.
- Switch synchronisers and capture registers live in input_conditioner.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4.
1. rst low with all raw inputs at 1 -> all outputs 0. Release rst at edge 0 -> Reset_Clean and Sensor_Clean rise after edge 6. Walk_Pulse and Reprog_Pulse are high for exactly the one cycle after edge 6.
2. Walk_Raw high for 3 cycles, then low -> Walk_Pulse never asserts and counter returns to 0. Walk_Raw high for 4 held cycles -> single Walk_Pulse 6 edges after the rise.
3. Bounce: Sensor_Raw toggles 1,0,1,0 each cycle, then holds 1 -> Sensor_Clean rises exactly 6 edges after the final 0->1 transition.
4. Selector_Raw=2'b10, Value_Raw=4'd9, then Reprog_Raw pressed -> in the Reprog_Pulse cycle, Selector_Out=2 and Value_Out=9. Change switches to 2'b01/4'd3 without pressing -> outputs stay 2/9.
5. Walk_Raw and Reprog_Raw rise on the same edge -> both pulses high in the same single cycle. Holding both for 100 cycles -> no further pulses.
6. Assert rst mid-count (c=2) with Walk_Raw high, release -> Walk_Pulse fires exactly once, 6 edges after release.
